// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;

endpackage

// File: rtl/seq_divider_32_if.sv
// Start/busy/done handshake and operand/result bus between ALU controller and divider.
interface seq_divider_32_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;
  logic             ovf;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, dz, ovf
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, dz, ovf
  );

endinterface

// File: rtl/twos_abs_neg.sv
// Combinational conditional two's-complement negate: out = neg ? -in : in.
module twos_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/seq_divider_32.sv
// Iterative restoring divider: one quotient bit per clock, signed/unsigned,
// divide-by-zero and signed-overflow flags, fixed latency.
module seq_divider_32
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_32_if.slave bus
);

  localparam int unsigned W = DIV_WIDTH;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [W-1:0]     pr_q, pr_d;
  logic [W-1:0]     qa_q, qa_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     raw_q, raw_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dzp_q, dzp_d;
  logic             ovfp_q, ovfp_d;

  logic             neg_a_c, neg_b_c;
  logic [W-1:0]     mag_a_c, mag_b_c;
  logic [W-1:0]     fix_q_c, fix_r_c;
  logic [W:0]       shifted_c, trial_c;

  assign neg_a_c = bus.is_signed & bus.dividend[W-1];
  assign neg_b_c = bus.is_signed & bus.divisor[W-1];

  twos_abs_neg #(.WIDTH(W)) u_abs_a (.in_i(bus.dividend), .neg_i(neg_a_c),     .out_o(mag_a_c));
  twos_abs_neg #(.WIDTH(W)) u_abs_b (.in_i(bus.divisor),  .neg_i(neg_b_c),     .out_o(mag_b_c));
  twos_abs_neg #(.WIDTH(W)) u_fix_q (.in_i(qa_q),         .neg_i(sa_q ^ sb_q), .out_o(fix_q_c));
  twos_abs_neg #(.WIDTH(W)) u_fix_r (.in_i(pr_q),         .neg_i(sa_q),        .out_o(fix_r_c));

  // Trial subtract in W+1 bits; the top bit is the borrow, i.e. "remainder too small".
  assign shifted_c = {pr_q, qa_q[W-1]};
  assign trial_c   = shifted_c - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    pr_d    = pr_q;
    qa_d    = qa_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dzp_d   = dzp_q;
    ovfp_d  = ovfp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = neg_a_c;
          sb_d    = neg_b_c;
          qa_d    = mag_a_c;
          dvs_d   = mag_b_c;
          raw_d   = bus.dividend;
          dzp_d   = (bus.divisor == '0);
          ovfp_d  = bus.is_signed && (bus.dividend == SIGNED_MIN) && (bus.divisor == DZ_QUOTIENT);
          pr_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        pr_d  = trial_c[W] ? shifted_c[W-1:0] : trial_c[W-1:0];
        qa_d  = {qa_q[W-2:0], ~trial_c[W]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dz_d    = dzp_q;
        ovf_d   = ovfp_q;
        state_d = IDLE;
        if (dzp_q) begin
          quot_d = DZ_QUOTIENT;
          remo_d = raw_q;
        end else if (ovfp_q) begin
          quot_d = SIGNED_MIN;
          remo_d = '0;
        end else begin
          quot_d = fix_q_c;
          remo_d = fix_r_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      pr_q    <= '0;
      qa_q    <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dzp_q   <= 1'b0;
      ovfp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      pr_q    <= pr_d;
      qa_q    <= qa_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dzp_q   <= dzp_d;
      ovfp_q  <= ovfp_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
Iterative restoring divider for the SimpleALU. It is the inverse-operation companion to the combinational adder datapath.
Accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock. It returns quotient, remainder and status flags with a done pulse after a fixed latency.
Sits beside the adder/ALU as a multi-cycle execution unit, with a start/busy/done handshake to the ALU controller.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high from the accept edge until the edge that asserts done
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  registered quotient, held until the next done
remainder  output  WIDTH  registered remainder, held until the next done
dz  output  1  divide-by-zero flag, valid with done, held
ovf  output  1  signed overflow flag (-2^(WIDTH-1) / -1), valid with done, held

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy, done, quotient, remainder, dz and ovf all 0; iteration counter 0.
  - Any in-flight operation is discarded.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - If start=1 on an edge (the accept edge, edge 0), latch is_signed, the operand magnitudes, and the sign of the dividend and divisor.
  - Compute dz (divisor==0) and ovf (is_signed, dividend==100..0, divisor==all ones).
  - Clear the partial remainder and counter; busy=1; go to CALC.
- CALC: edges 1..WIDTH each perform one restoring step:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude using WIDTH+1-bit arithmetic.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After the WIDTH-th step, go to FIX.
- FIX (edge WIDTH+1): register the outputs, pulse done=1, set busy=0, return to IDLE.
  - Signed quotient is negated if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - dz=1 overrides: quotient = all ones, remainder = raw dividend.
  - ovf=1 overrides: quotient = 100..0, remainder = 0.
- Latency: done is high in the cycle after edge WIDTH+1. The latency is fixed and includes dz/ovf cases.
- done is high for exactly one cycle. The results and flags hold until the next FIX edge.
- start while busy=1 is ignored, with no queuing.
- start on the same edge that done rises (the FIX edge) is ignored, because busy was 1 at that edge. start in the done-high cycle is accepted.
- Back-to-back operations: minimum issue interval is WIDTH+2 cycles.
- Operand inputs may change freely after the accept edge.
- Unsigned mode: dz and ovf semantics as above, except ovf is always 0.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE, CALC, FIX).
  - Counter width constant, clog2(WIDTH+1).
  - DZ_QUOTIENT constant (all ones).
  - Signed-minimum constant.
- One natural sub-module, twos_abs_neg: combinational conditional negate (out = neg ? -in : in), WIDTH-parameterised.
  - Instantiated for the dividend/divisor magnitudes and for the quotient/remainder sign fix-up.
- Trial subtraction stays inline in the datapath.

Test Plan:
- Unsigned 100 / 7 -> done exactly 34 cycles after accept (WIDTH=32): quotient=14, remainder=2, dz=0, ovf=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also signed 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero:
  - 0x12345678 / 0 -> dz=1, quotient=0xFFFFFFFF, remainder=0x12345678, same latency.
  - Signed 0x80000000 / 0xFFFFFFFF -> ovf=1, quotient=0x80000000, remainder=0.
- Handshake:
  - start held high continuously -> operations issue every 34 cycles.
  - A start pulse at cycle 10 of a busy period is ignored: no extra done, and the results equal the first operation.
- Reset mid-CALC: drop rst_n at cycle 15 after accept -> all outputs 0 immediately (asynchronous). After release, a new 0xFFFFFFFF / 1 unsigned op -> quotient=0xFFFFFFFF, remainder=0.
- Randomised 10k operands in both modes against a reference model. Also cover boundary values: divisor > dividend -> quotient=0, remainder=dividend; dividend=0 -> 0/0.
